// File: rtl/class_fifo.sv
// ============================================================================
// Module   : class_fifo
// Brief    : Single-clock circular FIFO with programmable almost-full /
//            almost-empty thresholds, occupancy count and sticky
//            overflow/underflow error bits. Used per traffic class on the
//            emissor side and per destination on the receptor side of the
//            transaction-layer referee.
// Options  : CLASS_FIFO_FWFT_EN - when defined, first-word-fall-through read
//            (data_out shows the head combinationally, pop acknowledges it);
//            when undefined, registered read with one-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module class_fifo #(
    parameter int LINE_SIZE = 12,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [LINE_SIZE-1:0] data_in,
    input  logic [ADDR_BITS:0]   almost_full_th,
    input  logic [ADDR_BITS:0]   almost_empty_th,
    output logic [LINE_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic [1:0]           fifo_error
);

    localparam int                 DEPTH      = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] c_DEPTH    = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0] c_CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] c_PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [LINE_SIZE-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic [ADDR_BITS:0]   w_count_next;
    logic [1:0]           r_fifo_error;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop_ok;
    logic                 w_push_ok;

    // Flags come straight from the count register so they track reset and
    // threshold changes without waiting for an edge.
    assign w_full       = (r_count == c_DEPTH);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= almost_full_th);
    assign almost_empty = (r_count <= almost_empty_th);
    assign count        = r_count;
    assign fifo_error   = r_fifo_error;

    // A push into a full FIFO is only safe when a pop frees a slot on the
    // same edge; a pop on empty is never accepted, even with a push present.
    assign w_pop_ok  = pop && !w_empty;
    assign w_push_ok = push && (!w_full || w_pop_ok);

    // Occupancy update: simultaneous accepted push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and sticky error bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fifo_error <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count      <= w_count_next;
            r_fifo_error <= r_fifo_error | {push && !w_push_ok, pop && !w_pop_ok};
        end
    end

`ifdef CLASS_FIFO_FWFT_EN
    // Head of queue is always visible; pop just acknowledges it.
    assign data_out  = r_mem[r_rd_ptr];
    assign valid_out = !w_empty;
`else
    logic [LINE_SIZE-1:0] r_data_out;
    logic                 r_valid_out;

    // Registered read: word appears one cycle after an accepted pop and is
    // held afterwards; valid_out pulses only for the fresh word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_pop_ok;
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
`endif

endmodule

`default_nettype wire

// File: doc/class_fifo.md
Name: class_fifo

Overview:
- Single-clock circular FIFO with programmable almost-full/almost-empty thresholds.
- Instantiated four times on each side of the transaction-layer referee:
  - emissor bank: one per traffic class, feeds the referee's pop side and drives its almost_empty inputs;
  - receptor bank: one per destination, consumes the referee's push_signal/data_out and drives its almost_full inputs.
- Also reports full/empty, occupancy and sticky overflow/underflow errors.

Parameters:
- LINE_SIZE, 12, data word width (class[1:0], dest[1:0], data[7:0])
- ADDR_BITS, 3, pointer width; depth = 2**ADDR_BITS entries

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- push  input  1  write request, data_in written when accepted
- pop  input  1  read request
- data_in  input  LINE_SIZE  write data
- almost_full_th  input  ADDR_BITS+1  almost_full threshold, quasi-static
- almost_empty_th  input  ADDR_BITS+1  almost_empty threshold, quasi-static
- data_out  output  LINE_SIZE  read data
- valid_out  output  1  data_out holds a freshly popped word
- full  output  1  count == depth
- empty  output  1  count == 0
- almost_full  output  1  count >= almost_full_th
- almost_empty  output  1  count <= almost_empty_th
- count  output  ADDR_BITS+1  current occupancy, 0..depth
- fifo_error  output  2  sticky: bit1 overflow, bit0 underflow

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - On reset: wr_ptr, rd_ptr, count, data_out, valid_out and fifo_error all go to 0.
  - Memory contents are not reset.
  - Flags are combinational from count, so during reset: empty=1, full=0, almost_empty=1, almost_full=(almost_full_th==0).
  - Reset mid-operation discards all stored words immediately, with no wait for a clock edge.
- Pointers:
  - ADDR_BITS wide; wrap naturally from depth-1 to 0.
  - count is a separate ADDR_BITS+1 register, never derived from pointer difference.
- pop_ok = pop && !empty.
- push_ok = push && (!full || pop_ok).
  - Push into a full FIFO is accepted only when a pop is accepted in the same cycle.
- Write: if push_ok, mem[wr_ptr] <= data_in and wr_ptr++.
- Read (non-FWFT):
  - if pop_ok: data_out <= mem[rd_ptr], rd_ptr++, valid_out <= 1;
  - otherwise valid_out <= 0 and data_out holds its previous value.
  - Latency: one cycle from pop to data_out/valid_out.
- count update:
  - push_ok only: +1;
  - pop_ok only: -1;
  - both, or neither: unchanged.
  - Never exceeds depth and never underflows.
- Simultaneous push and pop:
  - on empty: push accepted, pop rejected, and underflow is flagged; the word appears only on a later pop;
  - on full: both accepted, count stays at depth.
- Errors:
  - push && !push_ok sets fifo_error[1]; data_in is dropped and nothing else changes.
  - pop && !pop_ok sets fifo_error[0]; pointers and data_out are unchanged, valid_out=0.
  - Both bits are sticky until reset.
- Thresholds:
  - Compared unsigned against the current count register.
  - A threshold above depth makes almost_full never assert.
  - A threshold of depth makes almost_empty always assert.
  - Thresholds may change at any time; the flags follow on the same cycle.

Optional Feature:
- Macro: CLASS_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally, valid_out = !empty;
  - pop acts as an acknowledge of the current head and advances rd_ptr on the edge;
  - zero read latency; error, count and flag rules are unchanged.
- Undefined: registered read with one-cycle latency, as described above.

Test Plan:
- Reset then idle, almost_full_th=6, almost_empty_th=1 -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, fifo_error=0, data_out=0.
- Push 0x1A5, 0x2B6, 0x3C7 on consecutive cycles, then pop three times -> data_out 0x1A5, 0x2B6, 0x3C7 each one cycle after its pop with valid_out=1; count goes 1,2,3,2,1,0; almost_empty deasserts when count=2.
- Push 9 words into depth 8 -> full=1 at count=8, almost_full=1 from count=6, ninth word dropped, fifo_error=2'b10; popping 8 words returns the first 8 in order.
- Full FIFO, push 0xFFF with pop in the same cycle -> count stays 8, no error; after draining, 0xFFF is the last word out.
- Empty FIFO, push 0x055 with pop in the same cycle -> count=1, fifo_error=2'b01, valid_out=0; the next pop returns 0x055.
- Push 12 and pop 12 interleaved (pointer wrap), then assert reset mid-burst with no clock edge -> order is preserved across the wrap; the asynchronous reset forces count=0, empty=1, valid_out=0 immediately.
